// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/exception sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/hazard_ctrl_mod_fwd.sv
// Combinational ALU-operand forwarding comparator; the younger MEM result beats WB.
module fwd_unit_mod
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_w_en_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_w_en_i,
    output logic [1:0]            fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (mem_w_en_i && (mem_rd_i == ex_rs_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (wb_w_en_i && (wb_rd_i == ex_rs_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_mod.sv
// Pipeline hazard and exception sequencer: load-use stalls, branch flushes,
// operand forwarding and the exception drain/halt sequence.
module hazard_ctrl_mod
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 4,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned EXC_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rs1_i,
    input  logic [REG_ADDR_W-1:0] ex_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_w_en_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_w_en_i,
    input  logic                  branch_taken_i,
    input  logic [2:0]            exc_flags_i,
    input  logic                  resume_i,
    output logic                  stall_pc_o,
    output logic                  stall_if_id_o,
    output logic                  flush_if_id_o,
    output logic                  flush_id_ex_o,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic                  halt_o,
    output logic [2:0]            exc_code_o,
    output logic [EXC_CNT_W-1:0]  exc_count_o
);

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    hz_state_e      state_q, state_d;
    logic [2:0]     drain_cnt_q, drain_cnt_d;
    logic           take_exc;
    logic           load_use;

    fwd_unit_mod #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .ex_rs_i    (ex_rs1_i),
        .mem_rd_i   (mem_rd_i),
        .mem_w_en_i (mem_w_en_i),
        .wb_rd_i    (wb_rd_i),
        .wb_w_en_i  (wb_w_en_i),
        .fwd_sel_o  (fwd_a_sel_o)
    );

    fwd_unit_mod #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .ex_rs_i    (ex_rs2_i),
        .mem_rd_i   (mem_rd_i),
        .mem_w_en_i (mem_w_en_i),
        .wb_rd_i    (wb_rd_i),
        .wb_w_en_i  (wb_w_en_i),
        .fwd_sel_o  (fwd_b_sel_o)
    );

    assign load_use = ex_is_load_i &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        take_exc      = 1'b0;
        stall_pc_o    = 1'b0;
        stall_if_id_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        unique case (state_q)
            RUN: begin
                if (exc_flags_i != 3'b000) begin
                    take_exc      = 1'b1;
                    stall_pc_o    = 1'b1;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    drain_cnt_d   = '0;
                    state_d       = DRAIN;
                end else if (branch_taken_i) begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (load_use) begin
                    // One bubble suffices: next cycle the load sits in MEM and the match vanishes
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end
            DRAIN: begin
                stall_pc_o    = 1'b1;
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                drain_cnt_d   = drain_cnt_q + 3'd1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                stall_pc_o    = 1'b1;
                stall_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                if (resume_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            exc_code_o  <= '0;
            exc_count_o <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            if (take_exc) begin
                exc_code_o <= exc_flags_i;
                if (exc_count_o != '1) begin
                    exc_count_o <= exc_count_o + EXC_CNT_W'(1);
                end
            end
        end
    end

    assign halt_o = (state_q == HALT);

endmodule

// File: tb/tb_hazard_ctrl_mod.sv
// Self-checking bench for hazard_ctrl_mod: directed scenarios plus a randomized
// run checked against a behavioural pipeline-control model.
module tb_hazard_ctrl_mod;

    localparam int DRAIN_CYCLES = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, mem_w_en, wb_w_en;
    logic       branch_taken, resume;
    logic [2:0] exc_flags;
    logic       stall_pc, stall_if_id, flush_if_id, flush_id_ex, halt;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [2:0] exc_code;
    logic [7:0] exc_count;

    int total = 0;
    int bad   = 0;

    hazard_ctrl_mod #(
        .REG_ADDR_W   (4),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .EXC_CNT_W    (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .ex_rs1_i       (ex_rs1),
        .ex_rs2_i       (ex_rs2),
        .ex_rd_i        (ex_rd),
        .ex_is_load_i   (ex_is_load),
        .mem_rd_i       (mem_rd),
        .mem_w_en_i     (mem_w_en),
        .wb_rd_i        (wb_rd),
        .wb_w_en_i      (wb_w_en),
        .branch_taken_i (branch_taken),
        .exc_flags_i    (exc_flags),
        .resume_i       (resume),
        .stall_pc_o     (stall_pc),
        .stall_if_id_o  (stall_if_id),
        .flush_if_id_o  (flush_if_id),
        .flush_id_ex_o  (flush_id_ex),
        .fwd_a_sel_o    (fwd_a_sel),
        .fwd_b_sel_o    (fwd_b_sel),
        .halt_o         (halt),
        .exc_code_o     (exc_code),
        .exc_count_o    (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rs1 = 4'd0; ex_rs2 = 4'd0;
        ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
        mem_w_en = 1'b0; wb_w_en = 1'b0; branch_taken = 1'b0;
        resume = 1'b0; exc_flags = 3'b000;
    endtask

    // Control strobes packed as {stall_pc, stall_if_id, flush_if_id, flush_id_ex, halt}
    function automatic logic [4:0] ctl();
        return {stall_pc, stall_if_id, flush_if_id, flush_id_ex, halt};
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({ctl(), fwd_a_sel, fwd_b_sel, exc_code, exc_count} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ctl=%b fa=%0d fb=%0d code=%0d cnt=%0d, want all 0",
                     ctl(), fwd_a_sel, fwd_b_sel, exc_code, exc_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (exc_count !== 8'd0 || halt !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got cnt=%0d halt=%b, want 0 0", exc_count, halt);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        ex_rs1 = 4'd3; mem_rd = 4'd3; mem_w_en = 1'b1; wb_rd = 4'd3; wb_w_en = 1'b1;
        #1;
        total++;
        if (fwd_a_sel !== 2'd1) begin
            bad++; $display("FAIL fwd_mem_priority: got %0d want 1", fwd_a_sel);
        end
        mem_w_en = 1'b0;
        #1;
        total++;
        if (fwd_a_sel !== 2'd2) begin
            bad++; $display("FAIL fwd_wb: got %0d want 2", fwd_a_sel);
        end
        ex_rs2 = 4'd5;
        #1;
        total++;
        if (fwd_b_sel !== 2'd0) begin
            bad++; $display("FAIL fwd_b_none: got %0d want 0", fwd_b_sel);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_is_load = 1'b1; ex_rd = 4'd2; id_rs2 = 4'd2; id_use_rs2 = 1'b1;
        #1;
        total++;
        if (ctl() !== 5'b11010) begin
            bad++; $display("FAIL load_use_stall: got %b want 11010", ctl());
        end
        @(posedge clk); #1;
        ex_is_load = 1'b0;
        #1;
        total++;
        if (ctl() !== 5'b00000) begin
            bad++; $display("FAIL load_use_clear: got %b want 00000", ctl());
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        ex_is_load = 1'b1; ex_rd = 4'd2; id_rs2 = 4'd2; id_use_rs2 = 1'b1;
        branch_taken = 1'b1;
        #1;
        total++;
        if (ctl() !== 5'b00110) begin
            bad++; $display("FAIL branch_over_load_use: got %b want 00110", ctl());
        end
        @(posedge clk); #1;
        clear_inputs();
        #1;
        total++;
        if (ctl() !== 5'b00000) begin
            bad++; $display("FAIL branch_one_cycle: got %b want 00000", ctl());
        end
    endtask

    task automatic test_exception();
        clear_inputs();
        exc_flags = 3'b010;
        #1;
        total++;
        if (ctl() !== 5'b10110) begin
            bad++; $display("FAIL exc_entry_strobes: got %b want 10110", ctl());
        end
        @(posedge clk); #1;
        exc_flags = 3'b000;
        total++;
        if (exc_code !== 3'b010 || exc_count !== 8'd1) begin
            bad++; $display("FAIL exc_capture: got code=%b cnt=%0d want 010 1", exc_code, exc_count);
        end
        for (int d = 0; d < DRAIN_CYCLES; d++) begin
            total++;
            if (ctl() !== 5'b10110) begin
                bad++; $display("FAIL drain_cycle%0d: got %b want 10110", d, ctl());
            end
            @(posedge clk); #1;
        end
        total++;
        if (ctl() !== 5'b11011) begin
            bad++; $display("FAIL halt_entry: got %b want 11011", ctl());
        end
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        total++;
        if (halt !== 1'b0 || exc_code !== 3'b010) begin
            bad++; $display("FAIL resume: got halt=%b code=%b want 0 010", halt, exc_code);
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        for (int i = 0; i < 256; i++) begin
            exc_flags = 3'b001;
            @(posedge clk); #1;
            exc_flags = 3'b000;
            repeat (DRAIN_CYCLES) @(posedge clk);
            #1;
            total++;
            if (halt !== 1'b1) begin
                bad++; $display("FAIL sat_halt_iter%0d: got %b want 1", i, halt);
            end
            resume = 1'b1;
            @(posedge clk); #1;
            resume = 1'b0;
        end
        total++;
        if (exc_count !== 8'd255) begin
            bad++; $display("FAIL saturation: got %0d want 255", exc_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        clear_inputs();
        exc_flags = 3'b100;
        @(posedge clk); #1;
        exc_flags = 3'b000;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ctl(), fwd_a_sel, fwd_b_sel, exc_code, exc_count} !== 22'd0) begin
            bad++;
            $display("FAIL reset_mid_drain: got ctl=%b code=%0d cnt=%0d want all 0",
                     ctl(), exc_code, exc_count);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit         m_halted;
        int         m_drain_left;
        logic [2:0] m_code;
        int         m_count;
        logic [4:0] e_ctl;
        logic [1:0] e_fa, e_fb;
        logic       lu;

        clear_inputs();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_halted = 1'b0; m_drain_left = 0; m_code = 3'b000; m_count = 0;
        @(posedge clk); #1;

        for (int n = 0; n < 400; n++) begin
            id_rs1 = 4'($urandom_range(0, 3)); id_rs2 = 4'($urandom_range(0, 3));
            ex_rs1 = 4'($urandom_range(0, 3)); ex_rs2 = 4'($urandom_range(0, 3));
            ex_rd  = 4'($urandom_range(0, 3)); mem_rd = 4'($urandom_range(0, 3));
            wb_rd  = 4'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            ex_is_load = 1'($urandom); mem_w_en = 1'($urandom); wb_w_en = 1'($urandom);
            branch_taken = ($urandom_range(0, 3) == 0);
            resume       = ($urandom_range(0, 2) == 0);
            exc_flags    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            #3;

            e_fa = (mem_w_en && mem_rd == ex_rs1) ? 2'd1 : (wb_w_en && wb_rd == ex_rs1) ? 2'd2 : 2'd0;
            e_fb = (mem_w_en && mem_rd == ex_rs2) ? 2'd1 : (wb_w_en && wb_rd == ex_rs2) ? 2'd2 : 2'd0;
            lu = ex_is_load && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            if (m_halted)                 e_ctl = 5'b11011;
            else if (m_drain_left > 0)    e_ctl = 5'b10110;
            else if (exc_flags != 3'b000) e_ctl = 5'b10110;
            else if (branch_taken)        e_ctl = 5'b00110;
            else if (lu)                  e_ctl = 5'b11010;
            else                          e_ctl = 5'b00000;

            total++;
            if ({ctl(), fwd_a_sel, fwd_b_sel, exc_code, exc_count} !==
                {e_ctl, e_fa, e_fb, m_code, 8'(m_count)}) begin
                bad++;
                $display("FAIL random_cycle%0d: got ctl=%b fa=%0d fb=%0d code=%b cnt=%0d want ctl=%b fa=%0d fb=%0d code=%b cnt=%0d",
                         n, ctl(), fwd_a_sel, fwd_b_sel, exc_code, exc_count,
                         e_ctl, e_fa, e_fb, m_code, m_count);
            end

            @(posedge clk);
            if (m_halted) begin
                if (resume) m_halted = 1'b0;
            end else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1'b1;
            end else if (exc_flags != 3'b000) begin
                m_drain_left = DRAIN_CYCLES;
                m_code       = exc_flags;
                m_count      = (m_count < 255) ? m_count + 1 : 255;
            end
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_exception();
        test_saturation();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mod.md
Name: hazard_ctrl_mod

Overview:
Pipeline hazard and exception sequencer for the 5-stage RISC pipeline (IF/ID/EX/MEM/WB).
- Consumes register addresses and write enables from the pipeline registers, the taken-branch indication from EX, and the exception flags from control_unit_mod.
- Produces stall/flush strobes for the PC and the IF/ID and ID/EX registers, and ALU-operand forwarding selects.
- Runs the exception drain/halt sequence.

Parameters:
REG_ADDR_W, 4, register-file address width.
DRAIN_CYCLES, 3, cycles spent retiring older instructions after an exception before halting (legal range 1 to 7).
EXC_CNT_W, 8, width of the saturating exception counter.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
id_rs1_i  in  REG_ADDR_W  rs1 of the instruction in ID.
id_rs2_i  in  REG_ADDR_W  rs2 of the instruction in ID.
id_use_rs1_i  in  1  ID instruction reads rs1.
id_use_rs2_i  in  1  ID instruction reads rs2.
ex_rs1_i  in  REG_ADDR_W  rs1 of the instruction in EX.
ex_rs2_i  in  REG_ADDR_W  rs2 of the instruction in EX.
ex_rd_i  in  REG_ADDR_W  destination register in EX.
ex_is_load_i  in  1  EX instruction is LOAD/LOADI.
mem_rd_i  in  REG_ADDR_W  destination register in MEM.
mem_w_en_i  in  1  MEM instruction writes the register file.
wb_rd_i  in  REG_ADDR_W  destination register in WB.
wb_w_en_i  in  1  WB instruction writes the register file.
branch_taken_i  in  1  EX resolved pc_sel != 0.
exc_flags_i  in  3  exception_flags from control_unit_mod (EX stage).
resume_i  in  1  leave HALT.
stall_pc_o  out  1  hold PC.
stall_if_id_o  out  1  hold IF/ID register.
flush_if_id_o  out  1  bubble IF/ID register.
flush_id_ex_o  out  1  bubble ID/EX register.
fwd_a_sel_o  out  2  ALU srcA forward: 0 = regfile, 1 = MEM, 2 = WB.
fwd_b_sel_o  out  2  ALU srcB forward, same encoding.
halt_o  out  1  pipeline halted.
exc_code_o  out  3  sticky copy of the last exception flags.
exc_count_o  out  EXC_CNT_W  saturating count of exceptions taken.

Behaviour:
- Reset (async, while rst_n=0): state=RUN, drain counter 0, exc_code_o=0, exc_count_o=0. All stall/flush outputs, halt_o and fwd selects are 0. Reset mid-DRAIN or in HALT returns to RUN immediately.
- Forwarding (combinational, every state):
  - fwd_a_sel=1 if mem_w_en_i and mem_rd_i==ex_rs1_i.
  - Otherwise fwd_a_sel=2 if wb_w_en_i and wb_rd_i==ex_rs1_i.
  - Otherwise 0. MEM has priority over WB. fwd_b_sel is identical using ex_rs2_i.
- FSM states: RUN, DRAIN, HALT (2-bit encoding).
- RUN, combinational priority: exception > branch > load-use.
  - Exception (exc_flags_i != 0): assert flush_if_id, flush_id_ex and stall_pc in this cycle. On the next clk edge: exc_code_o <= exc_flags_i, exc_count_o increments (saturates at all-ones), drain counter <= 0, state -> DRAIN.
  - Branch (branch_taken_i=1): flush_if_id=1 and flush_id_ex=1 for exactly this cycle. Load-use stall is suppressed. State stays RUN.
  - Load-use: ex_is_load_i and ((id_use_rs1_i and id_rs1_i==ex_rd_i) or (id_use_rs2_i and id_rs2_i==ex_rd_i)) gives stall_pc=1, stall_if_id=1, flush_id_ex=1. This costs exactly one bubble. The next cycle the load is in MEM and the match clears by itself; no state is used.
- DRAIN:
  - stall_pc=1, flush_if_id=1, flush_id_ex=1 every cycle. MEM/WB keep retiring.
  - The counter increments each cycle. When counter==DRAIN_CYCLES-1, state -> HALT.
  - exc_flags_i, branch_taken_i and resume_i are ignored.
- HALT:
  - halt_o=1, stall_pc=1, stall_if_id=1, flush_id_ex=1.
  - resume_i=1 gives state -> RUN on the next edge. exc_code_o is kept (sticky) until the next exception overwrites it.
  - New exceptions are ignored.
- resume_i outside HALT has no effect. exc_count_o never wraps.
- halt_o is the registered state decode: 0 in RUN and DRAIN, 1 in HALT.

Decomposition:
- Shared package hazard_pkg: state enum {RUN, DRAIN, HALT}, forward-select constants FWD_RF=0, FWD_MEM=1, FWD_WB=2.
- One sub-module, fwd_unit_mod: purely combinational forwarding comparator, instantiated twice (operands A and B).

Test Plan:
- Reset: drive rst_n=0 for 2 ns. Check all outputs are 0 and halt_o=0; check exc_count_o=0 after release.
- Forwarding: ex_rs1=3, mem_rd=3 with mem_w_en=1, wb_rd=3 with wb_w_en=1 -> fwd_a_sel=1. Drop mem_w_en -> fwd_a_sel=2. Set ex_rs2=5 with no match -> fwd_b_sel=0.
- Load-use: ex_is_load=1, ex_rd=2, id_rs2=2, id_use_rs2=1 -> stall_pc=stall_if_id=flush_id_ex=1 for one cycle. Clear ex_is_load next cycle -> all 0.
- Branch vs load-use: branch_taken=1 with the same load-use match -> flush_if_id=flush_id_ex=1, stall_pc=0.
- Exception:
  - Pulse exc_flags=3'b010 for one cycle -> exc_code_o=3'b010, exc_count_o=1. Flushes stay asserted for 3 DRAIN cycles; halt_o=1 on the 4th.
  - Pulse resume_i -> RUN and halt_o=0, exc_code_o still 3'b010.
- Saturation/reset: take 256 exceptions (resume each) -> exc_count_o=255. Assert rst_n=0 mid-DRAIN -> immediate RUN, all outputs 0.
